// File: rtl/frame_pkg.sv
// frame_pkg: shared types and frame geometry for the frame write arbiter.
// Optional build macro STARVATION_GUARD_EN is consumed by the top.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } fw_state_t;

  typedef logic [23:0] pixel_t;

  localparam int H_RES        = 320;
  localparam int V_RES        = 240;
  localparam int FRAME_PIXELS = H_RES * V_RES;

endpackage

// File: rtl/frame_write_arbiter_fifo.sv
// pixel_fifo: synchronous FIFO with flush, occupancy count and
// push-while-full allowed when a pop happens in the same cycle.
module pixel_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 24,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // pointer and occupancy bookkeeping; flush empties in one cycle
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // storage array, no reset needed on data
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !reset_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/frame_write_arbiter.sv
// frame_write_arbiter: buffers packed pixels and writes them into a shared
// single-port frame buffer; reads win unless STARVATION_GUARD_EN is defined.
module frame_write_arbiter
  import frame_pkg::*;
#(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_ready,
  input  pixel_t            RGB,
  input  logic              frame_start,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              rd_valid,
  output pixel_t            rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output pixel_t            mem_wdata,
  input  pixel_t            mem_rdata,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(H_RES * V_RES - 1);

  fw_state_t         state_q;
  fw_state_t         state_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] wr_addr_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              rd_valid_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  pixel_t            fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  logic              wr_slot;
  logic              guard_win;
  logic              wr_fire;
  logic              wr_last;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_t))
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (frame_start),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (RGB),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // writer may use the port when it has data and is not in DONE
  assign wr_slot = !reset && !frame_start &&
                   (state_q != DONE) && !fifo_empty;

`ifdef STARVATION_GUARD_EN
  logic guard_q;

  // writer steals a read slot when nearly full, never twice in a row
  assign guard_win = rd_req && wr_slot && !guard_q &&
                     (fifo_count >= CNT_W'(FIFO_DEPTH - 2));

  // remembers whether the guard won last cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      guard_q <= 1'b0;
    end else begin
      guard_q <= guard_win;
    end
  end
`else
  assign guard_win = 1'b0;
`endif

  assign rd_grant  = !reset && rd_req && !guard_win;
  assign wr_fire   = wr_slot && !rd_grant;
  assign wr_last   = wr_fire && (wr_addr_q == LAST_ADDR);

  assign fifo_pop  = wr_fire;
  assign fifo_push = pixel_ready && !frame_start;

  assign mem_we    = wr_fire;
  assign mem_addr  = rd_grant ? rd_addr : wr_addr_q;
  assign mem_wdata = wr_fire ? fifo_head : '0;

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_valid_q ? mem_rdata : '0;
  assign frame_done = (state_q == DONE);
  assign overflow   = ovf_q;
  assign busy       = (state_q == WRITE) || (fifo_count != '0);

  // next state, write address and sticky overflow
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    ovf_d     = ovf_q;
    if (wr_fire) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
    end
    if (pixel_ready && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (wr_last) begin
          state_d = DONE;
        end else if (!fifo_empty) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (wr_last) begin
          state_d = DONE;
        end else if (fifo_empty) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        wr_addr_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (frame_start) begin
      state_d   = IDLE;
      wr_addr_d = '0;
      ovf_d     = 1'b0;
    end
  end

  // state, address, overflow and read-valid registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_grant;
    end
  end

endmodule

// File: tb/tb_frame_write_arbiter.sv
// tb_frame_write_arbiter: randomized bench with a queue-based reference
// model of the pixel buffer, frame addressing and port arbitration.
module tb_frame_write_arbiter;
  import frame_pkg::*;

  localparam int AW    = 17;
  localparam int DEPTH = 16;
  localparam int FP    = FRAME_PIXELS;

  logic          clk = 1'b0;
  logic          reset;
  logic          pixel_ready;
  logic [23:0]   RGB;
  logic          frame_start;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_grant;
  logic          rd_valid;
  logic [23:0]   rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [23:0]   mem_wdata;
  logic [23:0]   mem_rdata;
  logic          frame_done;
  logic          overflow;
  logic          busy;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  frame_write_arbiter #(
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_ready (pixel_ready),
    .RGB         (RGB),
    .frame_start (frame_start),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_grant    (rd_grant),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .busy        (busy)
  );

  // frame-buffer BRAM: unwritten words read back a fixed pattern
  logic [23:0] bram [int];

  function automatic logic [23:0] rd_mem(input logic [AW-1:0] a);
    if (bram.exists(int'(a))) return bram[int'(a)];
    return {7'h0, a} ^ 24'hA5C3E1;
  endfunction

  always @(posedge clk) begin
    mem_rdata <= rd_mem(mem_addr);
    if (mem_we === 1'b1) bram[int'(mem_addr)] = mem_wdata;
  end

  // reference model: pixel queue, write pointer, frame phase
  typedef enum int {S_IDLE, S_WRITE, S_DONE} mst_t;
  logic [23:0] mq [$];
  int          m_addr;
  mst_t        m_st;
  bit          m_ovf;
  bit          m_vld;
  bit          m_gprev;
  logic [23:0] m_rd;
  logic [23:0] nxt_rd;
  bit          e_grant;
  bit          e_we;
  bit          e_gw;
  logic [70:0] exp_v;

  function automatic logic [70:0] obs();
    return {rd_grant, rd_valid, rd_valid ? rd_data : 24'h0, mem_we,
            (mem_we || rd_grant) ? mem_addr : {AW{1'b0}},
            mem_we ? mem_wdata : 24'h0,
            frame_done, overflow, busy};
  endfunction

  task automatic predict();
    logic [AW-1:0] ea;
    e_gw = 1'b0;
`ifdef STARVATION_GUARD_EN
    e_gw = rd_req && !frame_start && m_st != S_DONE &&
           mq.size() >= DEPTH - 2 && !m_gprev;
`endif
    e_grant = rd_req && !e_gw;
    e_we = !frame_start && m_st != S_DONE && mq.size() > 0 && !e_grant;
    ea = e_grant ? rd_addr : (e_we ? m_addr[AW-1:0] : {AW{1'b0}});
    exp_v = {e_grant, m_vld, m_vld ? m_rd : 24'h0, e_we, ea,
             e_we ? mq[0] : 24'h0, m_st == S_DONE, m_ovf,
             m_st == S_WRITE || mq.size() > 0};
    nxt_rd = e_grant ? rd_mem(rd_addr) : 24'h0;
  endtask

  task automatic commit();
    int sz;
    bit last;
    @(posedge clk);
    sz = mq.size();
    last = 1'b0;
    m_vld = e_grant;
    m_rd = nxt_rd;
    m_gprev = e_gw;
    if (frame_start) begin
      mq.delete();
      m_addr = 0;
      m_st = S_IDLE;
      m_ovf = 1'b0;
    end else begin
      if (e_we) begin
        last = (m_addr == FP - 1);
        void'(mq.pop_front());
        m_addr++;
      end
      if (pixel_ready) begin
        if (sz < DEPTH || e_we) mq.push_back(RGB);
        else m_ovf = 1'b1;
      end
      if (m_st == S_DONE) begin
        m_st = S_IDLE;
        m_addr = 0;
      end else if (last) m_st = S_DONE;
      else if (m_st == S_IDLE && sz > 0) m_st = S_WRITE;
      else if (m_st == S_WRITE && sz == 0) m_st = S_IDLE;
    end
    #1;
  endtask

  task automatic drive(input bit pr, input logic [23:0] px, input bit rq,
                       input logic [AW-1:0] ra, input bit fs);
    pixel_ready = pr;
    RGB = px;
    rd_req = rq;
    rd_addr = ra;
    frame_start = fs;
    predict();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pixel_ready = 1'b0;
    RGB = '0;
    rd_req = 1'b0;
    rd_addr = '0;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mq.delete();
    m_addr = 0;
    m_st = S_IDLE;
    m_ovf = 1'b0;
    m_vld = 1'b0;
    m_gprev = 1'b0;
    m_rd = '0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (obs() !== 71'h0 || rd_data !== 24'h0) begin
      $display("FAIL reset_hold got=%h required=0", obs());
    end else pass_cnt++;
    do_reset();
    drive(0, 24'h0, 0, '0, 0);
    total++;
    if (obs() !== 71'h0) begin
      $display("FAIL reset_release got=%h required=0", obs());
    end else pass_cnt++;
    commit();
    for (int c = 0; c < 3; c++) begin
      drive(1, 24'($urandom), 1, 17'd7, 0);
      commit();
    end
    reset = 1'b1;
    rd_req = 1'b0;
    pixel_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (obs() !== 71'h0) begin
      $display("FAIL reset_midframe got=%h required=0", obs());
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [23:0] px [3];
    int nw;
    px[0] = 24'hFF0000;
    px[1] = 24'h00FF00;
    px[2] = 24'h0000FF;
    nw = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(c < 3, c < 3 ? px[c] : 24'h0, 0, '0, 0);
      total++;
      if (obs() !== exp_v) begin
        $display("FAIL basic_cyc%0d got=%h required=%h", c, obs(), exp_v);
      end else pass_cnt++;
      if (mem_we === 1'b1 && nw < 3) begin
        total++;
        if (mem_addr !== nw[AW-1:0] || mem_wdata !== px[nw]) begin
          $display("FAIL basic_write%0d got=%h/%h required=%h/%h",
                   nw, mem_addr, mem_wdata, nw, px[nw]);
        end else pass_cnt++;
        nw++;
      end
      commit();
    end
    total++;
    if (nw !== 3 || busy !== 1'b0) begin
      $display("FAIL basic_end got=writes%0d busy%b required=3/0", nw, busy);
    end else pass_cnt++;
  endtask

  task automatic test_read_priority();
    logic [23:0] exp5;
    int nw;
    bit hold;
    nw = 0;
    do_reset();
    exp5 = rd_mem(17'd5);
    for (int c = 0; c < 10; c++) begin
      hold = (c < 6);
      drive(c < 2, 24'($urandom), hold, 17'd5, 0);
      total++;
      if (obs() !== exp_v) begin
        $display("FAIL rdpri_cyc%0d got=%h required=%h", c, obs(), exp_v);
      end else pass_cnt++;
      if (hold) begin
        total++;
        if (rd_grant !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'd5) begin
          $display("FAIL rdpri_hold%0d got=g%b we%b a%0d required=1/0/5",
                   c, rd_grant, mem_we, mem_addr);
        end else pass_cnt++;
      end
      if (c >= 1 && c <= 6) begin
        total++;
        if (rd_valid !== 1'b1 || rd_data !== exp5) begin
          $display("FAIL rdpri_data%0d got=%b/%h required=1/%h",
                   c, rd_valid, rd_data, exp5);
        end else pass_cnt++;
      end
      if (!hold && mem_we === 1'b1) begin
        total++;
        if (mem_addr !== nw[AW-1:0]) begin
          $display("FAIL rdpri_resume got=%0d required=%0d", mem_addr, nw);
        end else pass_cnt++;
        nw++;
      end
      commit();
    end
    total++;
    if (nw !== 2) begin
      $display("FAIL rdpri_count got=%0d required=2", nw);
    end else pass_cnt++;
  endtask

  task automatic test_frame_wrap();
    int errs, fd, last_a, after_a, nw, bad_c;
    logic [70:0] bad_o, bad_e;
    errs = 0; fd = 0; last_a = -1; after_a = -1; nw = 0; bad_c = -1;
    bad_o = '0; bad_e = '0;
    do_reset();
    for (int c = 0; c < FP + 5; c++) begin
      drive(c <= FP, 24'($urandom), 0, '0, 0);
      if (obs() !== exp_v) begin
        if (errs == 0) begin
          bad_c = c; bad_o = obs(); bad_e = exp_v;
        end
        errs++;
      end
      if (frame_done === 1'b1) fd++;
      if (mem_we === 1'b1) begin
        if (fd == 0) last_a = int'(mem_addr);
        else if (after_a < 0) after_a = int'(mem_addr);
        nw++;
      end
      commit();
    end
    total++;
    if (errs != 0) begin
      $display("FAIL wrap_stream cyc%0d got=%h required=%h (%0d cycles off)",
               bad_c, bad_o, bad_e, errs);
    end else pass_cnt++;
    total++;
    if (fd != 1) $display("FAIL wrap_done_pulses got=%0d required=1", fd);
    else pass_cnt++;
    total++;
    if (last_a != FP - 1) begin
      $display("FAIL wrap_last_addr got=%0d required=%0d", last_a, FP - 1);
    end else pass_cnt++;
    total++;
    if (after_a != 0 || nw != FP + 1) begin
      $display("FAIL wrap_next got=addr%0d n%0d required=0/%0d",
               after_a, nw, FP + 1);
    end else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(c < 17, 24'($urandom), 1, 17'($urandom), 0);
      total++;
      if (obs() !== exp_v) begin
        $display("FAIL ovf_cyc%0d got=%h required=%h", c, obs(), exp_v);
      end else pass_cnt++;
      commit();
    end
`ifndef STARVATION_GUARD_EN
    total++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL ovf_sticky got=%b/%b required=1/1", overflow, busy);
    end else pass_cnt++;
`endif
    drive(0, 24'h0, 0, '0, 1);
    total++;
    if (obs() !== exp_v) begin
      $display("FAIL ovf_flush got=%h required=%h", obs(), exp_v);
    end else pass_cnt++;
    commit();
    drive(0, 24'h0, 0, '0, 0);
    total++;
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL ovf_clear got=%b/%b required=0/0", overflow, busy);
    end else pass_cnt++;
    commit();
  endtask

  task automatic test_frame_start();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      drive(c < 10, 24'($urandom), 0, '0, 0);
      total++;
      if (obs() !== exp_v) begin
        $display("FAIL fs_fill%0d got=%h required=%h", c, obs(), exp_v);
      end else pass_cnt++;
      commit();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1, 24'($urandom), 1, 17'd3, 0);
      commit();
    end
    drive(1, 24'h123456, 0, '0, 1);
    total++;
    if (mem_we !== 1'b0) $display("FAIL fs_cycle_we got=%b required=0", mem_we);
    else pass_cnt++;
    commit();
    drive(0, 24'h0, 0, '0, 0);
    total++;
    if (busy !== 1'b0 || overflow !== 1'b0 || mem_we !== 1'b0) begin
      $display("FAIL fs_flushed got=%b%b%b required=000",
               busy, overflow, mem_we);
    end else pass_cnt++;
    commit();
    drive(1, 24'hABCDEF, 0, '0, 0);
    commit();
    drive(0, 24'h0, 0, '0, 0);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 17'd0 || mem_wdata !== 24'hABCDEF) begin
      $display("FAIL fs_restart got=%b/%0d/%h required=1/0/abcdef",
               mem_we, mem_addr, mem_wdata);
    end else pass_cnt++;
    commit();
  endtask

  task automatic test_random();
    int errs, bad_c;
    logic [70:0] bad_o, bad_e;
    bit rq;
    errs = 0; bad_c = -1; bad_o = '0; bad_e = '0; rq = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      if ($urandom_range(0, 7) == 0) rq = ~rq;
      drive($urandom_range(0, 2) != 0, 24'($urandom), rq,
            17'($urandom_range(0, FP - 1)), $urandom_range(0, 299) == 0);
      if (obs() !== exp_v) begin
        if (errs == 0) begin
          bad_c = c; bad_o = obs(); bad_e = exp_v;
        end
        errs++;
      end
      commit();
    end
    total++;
    if (errs != 0) begin
      $display("FAIL random cyc%0d got=%h required=%h (%0d cycles off)",
               bad_c, bad_o, bad_e, errs);
    end else pass_cnt++;
  endtask

`ifdef STARVATION_GUARD_EN
  task automatic test_guard();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      drive(1, 24'($urandom), 1, 17'd9, 0);
      total++;
      if (rd_grant !== 1'b1 || mem_we !== 1'b0) begin
        $display("FAIL guard_fill%0d got=%b/%b required=1/0",
                 c, rd_grant, mem_we);
      end else pass_cnt++;
      commit();
    end
    drive(1, 24'($urandom), 1, 17'd9, 0);
    total++;
    if (rd_grant !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 17'd0) begin
      $display("FAIL guard_win got=%b/%b/%0d required=0/1/0",
               rd_grant, mem_we, mem_addr);
    end else pass_cnt++;
    commit();
    drive(1, 24'($urandom), 1, 17'd9, 0);
    total++;
    if (rd_grant !== 1'b1 || mem_we !== 1'b0) begin
      $display("FAIL guard_no_repeat got=%b/%b required=1/0", rd_grant, mem_we);
    end else pass_cnt++;
    commit();
    drive(1, 24'($urandom), 1, 17'd9, 0);
    total++;
    if (rd_grant !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 17'd1) begin
      $display("FAIL guard_again got=%b/%b/%0d required=0/1/1",
               rd_grant, mem_we, mem_addr);
    end else pass_cnt++;
    commit();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_read_priority();
    test_overflow();
    test_frame_start();
`ifdef STARVATION_GUARD_EN
    test_guard();
`endif
    test_random();
    test_frame_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/frame_write_arbiter.md
Name: frame_write_arbiter

Overview:
- Takes packed 24-bit pixels (RGB + pixel_ready pulse) from the UART pixel-packing stage and buffers them in a small internal FIFO.
- Writes them sequentially into a single-port frame-buffer BRAM.
- Shares that BRAM port with the display read path; display reads have priority by default.
- Sits between the pixel packer, the frame-buffer RAM and the VGA fetch logic.

Parameters:
- H_RES, 320, active pixels per line
- V_RES, 240, active lines per frame
- ADDR_W, 17, BRAM address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- FIFO_DEPTH, 16, pixel FIFO entries (power of two)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_ready  in  1  one-cycle strobe: RGB is valid
- RGB  in  24  packed pixel {R,G,B}
- frame_start  in  1  restart pulse: flush FIFO, write address to 0
- rd_req  in  1  display read request
- rd_addr  in  ADDR_W  display read address
- rd_grant  out  1  rd_req accepted this cycle
- rd_valid  out  1  rd_data valid (one cycle after grant)
- rd_data  out  24  display read data
- mem_addr  out  ADDR_W  BRAM address
- mem_we  out  1  BRAM write enable
- mem_wdata  out  24  BRAM write data
- mem_rdata  in  24  BRAM read data (1-cycle latency)
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
- overflow  out  1  sticky: a pixel was dropped
- busy  out  1  state is WRITE or FIFO not empty

Behaviour:
- Reset values: all outputs 0, FIFO empty, wr_addr=0, state IDLE.
- State machine has three states:
  - IDLE -> WRITE when the FIFO is not empty.
  - WRITE -> DONE after the write at address H_RES*V_RES-1.
  - WRITE -> IDLE when the FIFO is empty and the frame is incomplete.
  - DONE asserts frame_done for 1 cycle, sets wr_addr=0, then -> IDLE.
- Arbitration (combinational, per cycle):
  - If rd_req=1: rd_grant=1, mem_addr=rd_addr, mem_we=0.
  - Else, if the FIFO is not empty and state is IDLE/WRITE: pop the FIFO, mem_we=1, mem_addr=wr_addr, mem_wdata=FIFO head, wr_addr++.
- Read path:
  - rd_valid is rd_grant delayed 1 cycle.
  - rd_data = mem_rdata, registered pass-through in the rd_valid cycle.
- Write latency: a pixel accepted at cycle t is written no earlier than t+1, because the FIFO is registered.
- Wrap-around: the last write goes to address H_RES*V_RES-1 (76799 with defaults). The next frame starts at 0 with no gap other than the DONE cycle.
- FIFO full:
  - pixel_ready while full, with no pop in the same cycle: the pixel is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed, no drop.
- Empty: no write is issued and mem_we=0.
- frame_start has priority over everything except reset:
  - FIFO count goes to 0, wr_addr goes to 0, state goes to IDLE.
  - A pixel_ready in the same cycle is discarded.
  - overflow is cleared.
- Reset mid-frame: immediate return to reset values; partial frame contents in the BRAM are left untouched.

Optional Feature:
- Macro: STARVATION_GUARD_EN
- Defined:
  - When FIFO count >= FIFO_DEPTH-2 and rd_req=1, the writer wins for that cycle and rd_grant=0.
  - The requester must hold rd_req until granted.
  - The guard never wins two consecutive cycles.
- Undefined: rd_grant is rd_req and reads are never blocked.

Decomposition:
- Shared package frame_pkg holds:
  - typedef enum logic[1:0] {IDLE, WRITE, DONE} fw_state_t;
  - localparam FRAME_PIXELS = H_RES*V_RES;
  - typedef logic[23:0] pixel_t.
- Sub-module pixel_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by depth and width, instantiated once.

Test Plan:
- Reset, then 3 pixels 0xFF0000, 0x00FF00, 0x0000FF with rd_req=0 -> mem_we on 3 cycles at addr 0,1,2 with matching data; busy falls afterwards.
- rd_req held high with rd_addr=5 while 2 pixels are queued -> rd_grant=1, no writes while held; rd_valid one cycle later with rd_data=mem_rdata; writes resume at addr 0 after release.
- Stream H_RES*V_RES pixels -> last write at addr 76799; frame_done pulses exactly once; next pixel writes to addr 0.
- rd_req=1 continuously and 17 pixels pushed with FIFO_DEPTH=16 -> 17th pixel dropped, overflow=1 and stays 1 until frame_start.
- 10 pixels written, then frame_start with 4 pixels queued and a pixel_ready in the same cycle -> FIFO empty, overflow=0, the next pixel writes to addr 0.
- With STARVATION_GUARD_EN, rd_req=1 and FIFO count=14 -> rd_grant=0 for exactly one cycle while one write occurs, then rd_grant=1.
